// File: rtl/axi_wr_job_sched_pkg.sv
// Shared constants for the output-write job scheduler: FSM encodings and counter width.
package axi_wr_job_sched_pkg;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE      = 3'd0;
    localparam sched_state_t S_LAUNCH    = 3'd1;
    localparam sched_state_t S_WAIT_BUSY = 3'd2;
    localparam sched_state_t S_WAIT_DONE = 3'd3;
    localparam sched_state_t S_RESP      = 3'd4;

    localparam int JOBS_DONE_WIDTH = 16;

endpackage

// File: rtl/axi_wr_job_sched_if.sv
// Per-core write-job request bus: cores post descriptors, the scheduler answers with accept/done pulses.
interface axi_wr_job_sched_if #(
    parameter int NUM_REQ             = 2,
    parameter int AXI_ADDR_WIDTH      = 64,
    parameter int AXI_XFER_SIZE_WIDTH = 32
);
    logic [NUM_REQ-1:0]                     req_valid;
    logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]      req_ptr;
    logic [NUM_REQ*AXI_XFER_SIZE_WIDTH-1:0] req_size;
    logic [NUM_REQ-1:0]                     req_ready;
    logic [NUM_REQ-1:0]                     req_done;

    modport master (
        output req_valid,
        output req_ptr,
        output req_size,
        input  req_ready,
        input  req_done
    );

    modport slave (
        input  req_valid,
        input  req_ptr,
        input  req_size,
        output req_ready,
        output req_done
    );
endinterface

// File: rtl/axi_wr_job_sched_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    int                   cand_s;
    logic [IDX_WIDTH-1:0] cand_idx_s;
    logic                 found_s;

    // Scan rotated request vector starting at the pointer
    always_comb begin
        grant      = '0;
        idx        = '0;
        found_s    = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = int'(ptr) + i;
            if (cand_s >= NUM_REQ) begin
                cand_s = cand_s - NUM_REQ;
            end else begin
                cand_s = cand_s;
            end
            cand_idx_s = IDX_WIDTH'(cand_s);
            if (!found_s && req[cand_idx_s]) begin
                found_s           = 1'b1;
                grant[cand_idx_s] = 1'b1;
                idx               = cand_idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/axi_wr_job_sched.sv
// Round-robin scheduler sharing one AXI output-write datapath between NUM_REQ compute cores.
module axi_wr_job_sched
    import axi_wr_job_sched_pkg::*;
#(
    parameter int NUM_REQ             = 2,
    parameter int AXI_ADDR_WIDTH      = 64,
    parameter int AXI_XFER_SIZE_WIDTH = 32,
    parameter int IDX_WIDTH           = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    axi_wr_job_sched_if.slave              req,
    output logic                           wr_start,
    input  logic                           wr_done,
    output logic [AXI_ADDR_WIDTH-1:0]      wr_data_ptr,
    output logic [AXI_XFER_SIZE_WIDTH-1:0] wr_data_size,
    output logic [IDX_WIDTH-1:0]           grant_idx,
    output logic                           busy,
    output logic [JOBS_DONE_WIDTH-1:0]     jobs_done
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

    sched_state_t                   state_r;
    sched_state_t                   state_nxt_s;
    logic [IDX_WIDTH-1:0]           rr_ptr_r;
    logic [IDX_WIDTH-1:0]           grant_idx_r;
    logic [AXI_ADDR_WIDTH-1:0]      ptr_r;
    logic [AXI_XFER_SIZE_WIDTH-1:0] size_r;
    logic                           wr_start_r;
    logic                           busy_r;
    logic [NUM_REQ-1:0]             req_done_r;
    logic [JOBS_DONE_WIDTH-1:0]     jobs_done_r;

    logic [NUM_REQ-1:0]             arb_grant_s;
    logic [IDX_WIDTH-1:0]           arb_idx_s;
    logic                           arb_any_s;
    logic                           accept_s;
    logic [AXI_ADDR_WIDTH-1:0]      sel_ptr_s;
    logic [AXI_XFER_SIZE_WIDTH-1:0] sel_size_s;
    logic [IDX_WIDTH-1:0]           done_idx_s;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_WIDTH-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_arb (
        .req   (req.req_valid),
        .ptr   (rr_ptr_r),
        .grant (arb_grant_s),
        .idx   (arb_idx_s),
        .any   (arb_any_s)
    );

    // Accept is gated by reset so no ready pulse leaks while rst is held
    assign accept_s      = (state_r == S_IDLE) && arb_any_s && wr_done && !rst;
    assign req.req_ready = accept_s ? arb_grant_s : '0;

    // Winner's descriptor slices
    always_comb begin
        sel_ptr_s  = '0;
        sel_size_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx_s == IDX_WIDTH'(i)) begin
                sel_ptr_s  = req.req_ptr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                sel_size_s = req.req_size[i*AXI_XFER_SIZE_WIDTH +: AXI_XFER_SIZE_WIDTH];
            end else begin
                sel_ptr_s  = sel_ptr_s;
                sel_size_s = sel_size_s;
            end
        end
    end

    // Next-state decode; zero-size jobs skip the datapath entirely
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (sel_size_s == '0) ? S_RESP : S_LAUNCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_LAUNCH: state_nxt_s = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!wr_done) begin
                    state_nxt_s = S_WAIT_DONE;
                end else begin
                    state_nxt_s = S_WAIT_BUSY;
                end
            end
            S_WAIT_DONE: begin
                if (wr_done) begin
                    state_nxt_s = S_RESP;
                end else begin
                    state_nxt_s = S_WAIT_DONE;
                end
            end
            S_RESP:  state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Completion index: a zero-size job reaches S_RESP straight from accept
    assign done_idx_s = accept_s ? arb_idx_s : grant_idx_r;

    // State, descriptor latch, pulses and counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            rr_ptr_r    <= '0;
            grant_idx_r <= '0;
            ptr_r       <= '0;
            size_r      <= '0;
            wr_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            req_done_r  <= '0;
            jobs_done_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
            wr_start_r <= (state_nxt_s == S_LAUNCH);
            if (accept_s) begin
                grant_idx_r <= arb_idx_s;
                ptr_r       <= sel_ptr_s;
                size_r      <= sel_size_s;
            end else begin
                grant_idx_r <= grant_idx_r;
                ptr_r       <= ptr_r;
                size_r      <= size_r;
            end
            if (state_nxt_s == S_RESP) begin
                req_done_r  <= idx_to_onehot(done_idx_s);
                jobs_done_r <= jobs_done_r + JOBS_DONE_WIDTH'(1);
            end else begin
                req_done_r  <= '0;
                jobs_done_r <= jobs_done_r;
            end
            if (state_r == S_RESP) begin
                rr_ptr_r <= (grant_idx_r == LAST_IDX) ? '0 : grant_idx_r + 1'b1;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign req.req_done = req_done_r;
    assign wr_start     = wr_start_r;
    assign wr_data_ptr  = ptr_r;
    assign wr_data_size = size_r;
    assign grant_idx    = grant_idx_r;
    assign busy         = busy_r;
    assign jobs_done    = jobs_done_r;

endmodule

// File: tb/tb_axi_wr_job_sched.sv
// Directed bench for axi_wr_job_sched: hand-computed expectations checked with immediate assertions.
module tb_axi_wr_job_sched;
    import axi_wr_job_sched_pkg::*;

    localparam int NR = 2;
    localparam int AW = 64;
    localparam int SW = 32;
    localparam int IW = 1;

    logic          clk;
    logic          rst;
    logic          wr_start;
    logic          wr_done;
    logic [AW-1:0] wr_data_ptr;
    logic [SW-1:0] wr_data_size;
    logic [IW-1:0] grant_idx;
    logic          busy;
    logic [15:0]   jobs_done;

    int total;
    int bad;

    axi_wr_job_sched_if #(.NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_XFER_SIZE_WIDTH(SW)) ifc ();

    axi_wr_job_sched #(
        .NUM_REQ(NR), .AXI_ADDR_WIDTH(AW), .AXI_XFER_SIZE_WIDTH(SW), .IDX_WIDTH(IW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (ifc),
        .wr_start     (wr_start),
        .wr_done      (wr_done),
        .wr_data_ptr  (wr_data_ptr),
        .wr_data_size (wr_data_size),
        .grant_idx    (grant_idx),
        .busy         (busy),
        .jobs_done    (jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Datapath model from S_LAUNCH: drop idle after start, hold busy, then go idle (ends in S_RESP cycle)
    task automatic serve(input int busy_cycles);
        tick();
        wr_done = 1'b0;
        tick();
        repeat (busy_cycles) tick();
        wr_done = 1'b1;
        tick();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst           = 1'b1;
        wr_done       = 1'b1;
        ifc.req_valid = '0;
        ifc.req_ptr   = '0;
        ifc.req_size  = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_wr_start", wr_start, 0);
        chk("rst_jobs", jobs_done, 0);
        chk("rst_ptr", wr_data_ptr, 0);
        chk("rst_size", wr_data_size, 0);
        chk("rst_grant", grant_idx, 0);
        chk("rst_ready", ifc.req_ready, 0);
        chk("rst_done", ifc.req_done, 0);

        // Single job on core0
        rst = 1'b0;
        tick();
        ifc.req_ptr[63:0]  = 64'h1000;
        ifc.req_size[31:0] = 32'h800;
        ifc.req_valid      = 2'b01;
        #1;
        chk("t1_ready", ifc.req_ready, 2'b01);
        tick();
        ifc.req_valid = 2'b00;
        chk("t1_ready_drop", ifc.req_ready, 0);
        chk("t1_start", wr_start, 1);
        chk("t1_ptr", wr_data_ptr, 64'h1000);
        chk("t1_size", wr_data_size, 32'h800);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_start_pulse", wr_start, 0);
        wr_done = 1'b0;
        tick();
        repeat (47) tick();
        chk("t1_no_early_done", ifc.req_done, 0);
        wr_done = 1'b1;
        tick();
        chk("t1_done", ifc.req_done, 2'b01);
        tick();
        chk("t1_done_pulse", ifc.req_done, 0);
        chk("t1_idle", busy, 0);
        chk("t1_jobs", jobs_done, 1);

        // Simultaneous requests at reset exit
        rst = 1'b1;
        ifc.req_ptr   = {64'hB000, 64'hA000};
        ifc.req_size  = {32'h20, 32'h10};
        ifc.req_valid = 2'b11;
        #1;
        chk("t2_ready_in_rst", ifc.req_ready, 0);
        tick();
        chk("t2_jobs_rst", jobs_done, 0);
        rst = 1'b0;
        #1;
        chk("t2_ready0", ifc.req_ready, 2'b01);
        tick();
        ifc.req_valid      = 2'b10;
        ifc.req_ptr[63:0]  = 64'hDEAD;
        chk("t2_grant0", grant_idx, 0);
        chk("t2_ptr0", wr_data_ptr, 64'hA000);
        chk("t2_size0", wr_data_size, 32'h10);
        chk("t2_loser_wait", ifc.req_ready, 0);
        serve(3);
        chk("t2_done0", ifc.req_done, 2'b01);
        chk("t2_ptr0_stable", wr_data_ptr, 64'hA000);
        chk("t2_ready_in_resp", ifc.req_ready, 0);
        tick();
        chk("t2_ready1", ifc.req_ready, 2'b10);
        tick();
        ifc.req_valid = 2'b00;
        chk("t2_grant1", grant_idx, 1);
        chk("t2_ptr1", wr_data_ptr, 64'hB000);
        chk("t2_size1", wr_data_size, 32'h20);
        serve(2);
        chk("t2_done1", ifc.req_done, 2'b10);
        tick();
        chk("t2_jobs", jobs_done, 2);

        // Fairness: both held for six jobs, from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ifc.req_ptr   = {64'h2200, 64'h1100};
        ifc.req_size  = {32'h4, 32'h4};
        ifc.req_valid = 2'b11;
        for (int j = 0; j < 6; j++) begin
            #1;
            chk("t3_ready", ifc.req_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            chk("t3_grant", grant_idx, j % 2);
            serve(1);
            chk("t3_done", ifc.req_done, (j % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        ifc.req_valid = 2'b00;
        chk("t3_jobs", jobs_done, 6);

        // Zero-size job on core1 skips the datapath
        ifc.req_size[63:32] = 32'h0;
        ifc.req_valid       = 2'b10;
        #1;
        chk("t4_ready", ifc.req_ready, 2'b10);
        tick();
        ifc.req_valid = 2'b00;
        chk("t4_no_start", wr_start, 0);
        chk("t4_done", ifc.req_done, 2'b10);
        tick();
        chk("t4_no_start2", wr_start, 0);
        chk("t4_done_pulse", ifc.req_done, 0);
        chk("t4_jobs", jobs_done, 7);

        // Reset while waiting on the datapath
        ifc.req_ptr[63:0]  = 64'h3000;
        ifc.req_size[31:0] = 32'h40;
        ifc.req_valid      = 2'b01;
        tick();
        ifc.req_valid = 2'b00;
        tick();
        wr_done = 1'b0;
        tick();
        tick();
        chk("t5_busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        chk("t5_busy", busy, 0);
        chk("t5_start", wr_start, 0);
        chk("t5_done", ifc.req_done, 0);
        chk("t5_ptr", wr_data_ptr, 0);
        chk("t5_size", wr_data_size, 0);
        chk("t5_jobs", jobs_done, 0);
        rst     = 1'b0;
        wr_done = 1'b1;
        tick();
        chk("t5_no_done", ifc.req_done, 0);
        ifc.req_ptr[127:64]  = 64'h5000;
        ifc.req_size[63:32]  = 32'h100;
        ifc.req_valid        = 2'b10;
        #1;
        chk("t5_ready1", ifc.req_ready, 2'b10);
        tick();
        ifc.req_valid = 2'b00;
        chk("t5_grant1", grant_idx, 1);
        chk("t5_ptr1", wr_data_ptr, 64'h5000);
        serve(2);
        chk("t5_done1", ifc.req_done, 2'b10);
        tick();
        chk("t5_jobs1", jobs_done, 1);

        // Datapath busy when core0 posts
        wr_done            = 1'b0;
        ifc.req_ptr[63:0]  = 64'h7000;
        ifc.req_size[31:0] = 32'h8;
        ifc.req_valid      = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t6_hold_ready", ifc.req_ready, 0);
            tick();
            chk("t6_hold_busy", busy, 0);
        end
        wr_done = 1'b1;
        #1;
        chk("t6_ready", ifc.req_ready, 2'b01);
        tick();
        ifc.req_valid = 2'b00;
        chk("t6_start", wr_start, 1);
        chk("t6_ptr", wr_data_ptr, 64'h7000);
        serve(1);
        chk("t6_done", ifc.req_done, 2'b01);
        tick();
        chk("t6_jobs", jobs_done, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_wr_job_sched.md
Name: axi_wr_job_sched

Overview:
- Shares the single AXI output-write datapath (transposer + trimmer + bram2axi write engine) between NUM_REQ compute cores.
- Each core posts a write job: destination pointer and byte size. The scheduler picks one job round-robin, latches its descriptor and pulses the datapath start.
- It steers the datapath buffer-read port to the granted core, waits for datapath completion, then returns a per-core done pulse.

Parameters:
- NUM_REQ, 2, number of requesting cores (>=2).
- AXI_ADDR_WIDTH, 64, destination pointer width.
- AXI_XFER_SIZE_WIDTH, 32, job size width in bytes.
- IDX_WIDTH, $clog2(NUM_REQ), grant index width.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-core job pending; held until accepted.
- req_ptr  in  NUM_REQ*AXI_ADDR_WIDTH  per-core destination address; slice i belongs to core i.
- req_size  in  NUM_REQ*AXI_XFER_SIZE_WIDTH  per-core size in bytes.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- wr_start  out  1  datapath start pulse.
- wr_done  in  1  datapath idle level: high when idle, low while busy.
- wr_data_ptr  out  AXI_ADDR_WIDTH  latched pointer to the datapath.
- wr_data_size  out  AXI_XFER_SIZE_WIDTH  latched size to the datapath.
- grant_idx  out  IDX_WIDTH  selects which core's output buffer drives the datapath rdaddr/rddata mux.
- busy  out  1  high whenever state != S_IDLE.
- jobs_done  out  16  completed-job counter.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to S_IDLE; RR pointer to 0.
  - Outputs forced to 0: req_ready, req_done, wr_start, wr_data_ptr, wr_data_size, grant_idx, busy, jobs_done.
  - Reset during any state abandons the job with no req_done. Integration must reset the datapath in the same cycle.
- FSM states: S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_RESP.
- S_IDLE:
  - Acts when |req_valid && wr_done. Winner = first set bit of req_valid at or after the RR pointer, wrapping modulo NUM_REQ.
  - Same edge: latch grant_idx, wr_data_ptr, wr_data_size from the winner's slices. Pulse req_ready[winner] (combinational, one cycle).
  - Next state: S_RESP if the winner's size is 0, otherwise S_LAUNCH.
  - If wr_done is low, nothing is accepted.
- S_LAUNCH: wr_start=1 for exactly one cycle, registered output. Go to S_WAIT_BUSY.
- S_WAIT_BUSY: wait for wr_done==0, then go to S_WAIT_DONE. The datapath drops wr_done the cycle after start, so this normally lasts 1 cycle.
- S_WAIT_DONE: wait for wr_done==1 with no timeout, then go to S_RESP.
- S_RESP:
  - req_done[grant_idx]=1 for one cycle; jobs_done += 1, wrapping at 16 bits.
  - RR pointer = grant_idx+1 modulo NUM_REQ, wrapping from NUM_REQ-1 to 0.
  - Go to S_IDLE.
- Latency, request to start: accept at edge T (valid seen in S_IDLE), wr_start high in cycle T+1.
- Latency, done to release: wr_done rising seen at edge D gives req_done in cycle D+1, and the next accept is possible at D+2.
- Descriptor stability: grant_idx, wr_data_ptr and wr_data_size stay stable from accept through S_RESP. req_ptr/req_size changes after accept are ignored.
- Simultaneous requests: exactly one accepted per job slot; losers stay pending with req_ready=0. One core never wins twice in a row while another core is requesting.
- req_valid dropping before accept is legal: the job is withdrawn and no pulse is issued.
- A req_valid still high in S_RESP for the same core is treated as a new job.

Decomposition:
- Shared package: state encodings (S_IDLE..S_RESP, 3-bit) and the jobs_done width constant (16).
- Sub-module rr_arbiter: combinational, parameter NUM_REQ. Inputs are the req vector and the pointer. Outputs are the one-hot grant, the index and an any-request flag. The FSM and descriptor registers stay in axi_wr_job_sched.

Test Plan:
- Single job: core0 ptr=0x1000, size=0x800 → req_ready[0] at T, wr_start at T+1, wr_data_ptr=0x1000. Model drops done at T+2 and raises it at T+50 → req_done[0] at T+51, jobs_done=1.
- Simultaneous: both cores valid at reset exit → core0 served first, then core1; ptr/size switch at the second accept; grant_idx 0 then 1.
- Fairness: both cores held valid for 6 jobs → grant order 0,1,0,1,0,1; jobs_done=6.
- Zero-size: core1 size=0 → req_ready[1], then req_done[1] 1 cycle later; wr_start never asserts.
- Reset mid-job: rst=1 during S_WAIT_DONE → next cycle all outputs 0, no req_done. A fresh core1 job afterwards completes normally with RR pointer=0.
- Datapath busy at entry: wr_done=0 while core0 is valid → no req_ready until wr_done=1, then accept on that edge.
